apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

APB completer with a word-addressed memory, programmable wait states and error response. It is the responder end of the team's APB bus and sits on the slave side of the APB interface, answering the master driver's transfers. It gives the environment a real RTL target for the master agent, the monitor and the scoreboard.

## Interface
- DEPTH, 16: number of 32-bit words; power of two, ≥2.
- WAIT_CYCLES, 0: wait states inserted in every ACCESS phase (0–15).
- pclk  in  1  bus clock; all logic on rising edge.
- prst  in  1  reset; synchronous and active-high.
- paddr  in  32  byte address.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  32  write data.
- psel  in  1  slave select.
- penable  in  1  ACCESS-phase strobe.
- prdata  out  32  read data; registered.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response; qualified by pready.

## Operation
- FSM states: IDLE, ACCESS. Wait counter: 4 bits.
- IDLE: if psel=1 and penable=0 (SETUP sampled), go to ACCESS. Load the counter with WAIT_CYCLES. Latch a decode of paddr/pwrite. For a read, load prdata from the memory or with 0.
- IDLE with psel=1 and penable=1 (no SETUP seen): ignore and stay in IDLE.
- ACCESS with psel=0: abort to IDLE. No write occurs. Outputs return to their idle values.
- ACCESS with counter≠0: decrement the counter; pready=0.
- ACCESS with counter=0: pready=1.
  - Write, valid address: commit pwdata at this edge.
  - Go to IDLE.
- Address valid when paddr[1:0]=0 and paddr < DEPTH*4. Word index = paddr[log2(DEPTH)+1:2].
- Invalid address:
  - pslverr=1 in the completing cycle.
  - A write has no effect.
  - A read returns prdata=0.
- pslverr=0 whenever pready=0.
- prdata keeps the last read value outside transfers. Writes do not change prdata.
- Memory write uses the pwdata present in the completing cycle.
- Back-to-back: a new SETUP may be sampled in the cycle right after completion, because the FSM is then in IDLE. There are no dead cycles beyond the APB SETUP phase.

## Timing
- Reset (prst=1 at a pclk edge) gives:
  - state=IDLE, counter=0
  - prdata=0, pready=0, pslverr=0
  - all memory words=0
- Reset mid-transfer aborts it; no write commits.
- Reset has priority over every other event.
- pready and pslverr are decoded only from registered state. There is no combinational path from APB inputs to outputs.
- Transfer length from the SETUP cycle: 2 + WAIT_CYCLES cycles. With WAIT_CYCLES=0, pready is high in the first ACCESS cycle.
- Read data is stable from the first ACCESS cycle through completion.
- A write is visible to a read whose SETUP is sampled the cycle after the write completes.

## Structure
- Package apb_pkg holds:
  - the state enum (IDLE, ACCESS)
  - APB_ADDR_W=32 and APB_DATA_W=32
  - the wait-counter width constant
  - an address-decode function returning {valid, index}
- Sub-module apb_slave_mem_array: DEPTH×32 storage with synchronous write, combinational read and synchronous clear on prst.
- The top level holds the FSM, the counter, the decode and the output registers.

## Test plan
- Reset: assert prst for 2 cycles, then read addresses 0x0–0x3C. Expect all prdata=0, pslverr=0, pready high in cycle 2 of each transfer.
- Write then read: WAIT_CYCLES=0. Write 0xDEADBEEF to 0x08, then read 0x08 back-to-back. Expect prdata=0xDEADBEEF. Each transfer takes 2 cycles.
- Wait states: WAIT_CYCLES=3. Read 0x04 after writing 0x12345678. Expect pready low for 3 ACCESS cycles and high on the 4th, with prdata stable 0x12345678 throughout.
- Errors:
  - Write 0xFFFFFFFF to 0x40 (out of range) and to 0x06 (misaligned). Expect pslverr=1 with pready=1 for each.
  - Then read 0x00. Expect 0 and pslverr=0.
- Abort:
  - Drop psel in the 2nd ACCESS cycle of a write of 0xA5A5A5A5 to 0x10 (WAIT_CYCLES=3). Expect no pready, and a later read of 0x10 returns the previous value.
  - Assert prst mid-write. Expect all outputs 0 and the memory cleared.

Source files
------------

// File: rtl/apb_slave_mem_pkg.sv
// Shared APB types, widths and the word-address decoder
// used by the memory-backed completer.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [APB_ADDR_W-3:0] index;
    } dec_t;

    function automatic dec_t apb_decode(
        input logic [APB_ADDR_W-1:0] addr,
        input int unsigned           depth
    );
        dec_t d;
        d.index = addr[APB_ADDR_W-1:2];
        d.valid = (addr[1:0] == 2'b00) &&
                  (64'(addr) < (64'(depth) << 2));
        return d;
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the master driver and the
// memory completer.
interface apb_slave_mem_if;
    import apb_pkg::*;

    logic [APB_ADDR_W-1:0] paddr;
    logic                  pwrite;
    logic [APB_DATA_W-1:0] pwdata;
    logic                  psel;
    logic                  penable;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, pwrite, pwdata, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, pwdata, psel, penable,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_mem_array.sv
// Word storage: synchronous write and clear,
// combinational read.
module apb_slave_mem_array
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int          AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] mem_q [DEPTH];
    logic [APB_DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer over a word memory with programmable
// wait states and an error response on bad addresses.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic           pclk,
    input  logic           prst,
    apb_slave_mem_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  valid_q, valid_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [APB_DATA_W-1:0] prdata_q, prdata_d;

    dec_t                  dec;
    logic                  dec_ok;
    logic [AW-1:0]         dec_idx;
    logic                  mem_we;
    logic [APB_DATA_W-1:0] mem_rdata;
    logic                  pready;

    // Upper index bits must be zero for an in-range word.
    always_comb begin
        dec     = apb_decode(bus.paddr, DEPTH);
        dec_ok  = dec.valid && ((dec.index >> AW) == '0);
        dec_idx = dec.index[AW-1:0];
    end

    apb_slave_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (pclk),
        .rst   (prst),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (bus.pwdata),
        .raddr (dec_idx),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        prdata_d = prdata_q;
        mem_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    write_d = bus.pwrite;
                    valid_d = dec_ok;
                    idx_d   = dec_idx;
                    if (!bus.pwrite) begin
                        prdata_d = dec_ok ? mem_rdata : '0;
                    end
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_we  = write_q && valid_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            prdata_q <= prdata_d;
        end
    end

    assign pready      = (state_q == ACCESS) && (cnt_q == '0);
    assign bus.pready  = pready;
    assign bus.pslverr = pready && !valid_q;
    assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance without
// wait states, one with three.
module tb_apb_slave_mem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    apb_slave_mem_if b0 ();
    apb_slave_mem_if b3 ();

    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .pclk (clk),
        .prst (rst),
        .bus  (b0.slave)
    );

    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(3)) dut3 (
        .pclk (clk),
        .prst (rst),
        .bus  (b3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic e,
                         input logic w, input logic [31:0] a,
                         input logic [31:0] wd);
        if (d == 0) begin
            b0.psel = s; b0.penable = e; b0.pwrite = w;
            b0.paddr = a; b0.pwdata = wd;
        end else begin
            b3.psel = s; b3.penable = e; b3.pwrite = w;
            b3.paddr = a; b3.pwdata = wd;
        end
    endtask

    function automatic logic [33:0] smp(input int d);
        if (d == 0) return {b0.pready, b0.pslverr, b0.prdata};
        return {b3.pready, b3.pslverr, b3.prdata};
    endfunction

    // Ends in the completing cycle with the bus still asserted,
    // so a following call issues its SETUP back-to-back.
    task automatic xfer(input int d, input logic w,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err,
                        output int nwait, output logic stable,
                        output logic early_err);
        logic [33:0] s;
        logic [31:0] first;
        nwait = 0;
        stable = 1'b1;
        early_err = 1'b0;
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b0, w, a, wd);
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b1, w, a, wd);
        s = smp(d);
        first = s[31:0];
        while (!s[33]) begin
            if (s[32]) early_err = 1'b1;
            nwait++;
            if (nwait > 20) begin
                chk("xfer_timeout", 32'(nwait), 32'd20);
                break;
            end
            @(posedge clk); #1;
            s = smp(d);
            if (s[31:0] !== first) stable = 1'b0;
        end
        rd = s[31:0];
        err = s[32];
    endtask

    task automatic idle(input int d);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    logic [31:0] rd;
    logic        err, stb, eerr;
    int          nw;
    logic [33:0] s;

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        s = smp(0);
        chk("rst0_out", {30'b0, s[33:32]}, 32'h0);
        chk("rst0_prdata", s[31:0], 32'h0);
        s = smp(3);
        chk("rst3_out", {30'b0, s[33:32]}, 32'h0);
        rst = 1'b0;

        for (int a = 0; a <= 32'h3C; a += 4) begin
            xfer(0, 1'b0, 32'(a), 32'h0, rd, err, nw, stb, eerr);
            chk($sformatf("rst_rd_%0h", a), rd, 32'h0);
            chk("rst_rd_err", {31'b0, err}, 32'h0);
            chk("rst_rd_len", 32'(nw), 32'd0);
        end

        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, rd, err, nw, stb, eerr);
        chk("wr08_prdata_kept", rd, 32'h0);
        chk("wr08_err", {31'b0, err}, 32'h0);
        chk("wr08_len", 32'(nw), 32'd0);
        xfer(0, 1'b0, 32'h08, 32'h0, rd, err, nw, stb, eerr);
        chk("rd08", rd, 32'hDEADBEEF);
        chk("rd08_len", 32'(nw), 32'd0);
        idle(0);

        xfer(3, 1'b1, 32'h04, 32'h12345678, rd, err, nw, stb, eerr);
        chk("w3_wr_len", 32'(nw), 32'd3);
        chk("w3_wr_early_err", {31'b0, eerr}, 32'h0);
        xfer(3, 1'b0, 32'h04, 32'h0, rd, err, nw, stb, eerr);
        chk("w3_rd_len", 32'(nw), 32'd3);
        chk("w3_rd_data", rd, 32'h12345678);
        chk("w3_rd_stable", {31'b0, stb}, 32'h1);
        chk("w3_rd_err", {31'b0, err}, 32'h0);
        idle(3);

        xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, rd, err, nw, stb, eerr);
        chk("err_wr40", {31'b0, err}, 32'h1);
        xfer(0, 1'b1, 32'h06, 32'hFFFFFFFF, rd, err, nw, stb, eerr);
        chk("err_wr06", {31'b0, err}, 32'h1);
        xfer(0, 1'b0, 32'h00, 32'h0, rd, err, nw, stb, eerr);
        chk("rd00_data", rd, 32'h0);
        chk("rd00_err", {31'b0, err}, 32'h0);
        xfer(0, 1'b0, 32'h04, 32'h0, rd, err, nw, stb, eerr);
        chk("rd04_untouched", rd, 32'h0);
        xfer(0, 1'b0, 32'h08, 32'h0, rd, err, nw, stb, eerr);
        chk("rd08_again", rd, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h40, 32'h0, rd, err, nw, stb, eerr);
        chk("rd40_data", rd, 32'h0);
        chk("rd40_err", {31'b0, err}, 32'h1);
        xfer(0, 1'b0, 32'h3C, 32'h0, rd, err, nw, stb, eerr);
        chk("rd3c_err", {31'b0, err}, 32'h0);
        idle(0);

        xfer(3, 1'b1, 32'h10, 32'h11111111, rd, err, nw, stb, eerr);
        idle(3);
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b0, 1'b1, 32'h10, 32'hA5A5A5A5);
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5);
        s = smp(3);
        chk("abort_acc1_rdy", {31'b0, s[33]}, 32'h0);
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b0, 1'b0, 32'h10, 32'hA5A5A5A5);
        s = smp(3);
        chk("abort_acc2_rdy", {31'b0, s[33]}, 32'h0);
        @(posedge clk); #1;
        s = smp(3);
        chk("abort_idle_out", {30'b0, s[33:32]}, 32'h0);
        xfer(3, 1'b0, 32'h10, 32'h0, rd, err, nw, stb, eerr);
        chk("abort_rd10", rd, 32'h11111111);

        @(posedge clk); #1;
        drive(3, 1'b1, 1'b0, 1'b1, 32'h14, 32'h00000077);
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 1'b1, 32'h14, 32'h00000077);
        rst = 1'b1;
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s = smp(3);
        chk("mrst3_ctl", {30'b0, s[33:32]}, 32'h0);
        chk("mrst3_prdata", s[31:0], 32'h0);
        s = smp(0);
        chk("mrst0_prdata", s[31:0], 32'h0);
        rst = 1'b0;
        xfer(3, 1'b0, 32'h10, 32'h0, rd, err, nw, stb, eerr);
        chk("mrst_rd10", rd, 32'h0);
        xfer(3, 1'b0, 32'h14, 32'h0, rd, err, nw, stb, eerr);
        chk("mrst_rd14", rd, 32'h0);
        idle(3);
        xfer(0, 1'b0, 32'h08, 32'h0, rd, err, nw, stb, eerr);
        chk("mrst_rd08", rd, 32'h0);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
